// File: rtl/gyr_resp_capture_if.sv
// Gyrator response capture bus: sweep control, ADC sample stream and result handshake.
// Optional r_avg member is present only when GYR_RESP_CAPTURE_AVG_EN is defined.
interface gyr_resp_capture_if #(
    parameter int DW = 12,
    parameter int NW = 8
);
    logic                 start;
    logic [NW-1:0]        n_samp;
    logic                 s_valid;
    logic signed [DW-1:0] s_data;
    logic                 busy;
    logic                 r_valid;
    logic                 r_ready;
    logic signed [DW-1:0] r_max;
    logic signed [DW-1:0] r_min;
    logic [DW:0]          r_pp;
    logic [NW-1:0]        r_idx;
    logic                 drop;
`ifdef GYR_RESP_CAPTURE_AVG_EN
    logic signed [DW-1:0] r_avg;
`endif

    modport master (
        output start, n_samp, s_valid, s_data, r_ready,
`ifdef GYR_RESP_CAPTURE_AVG_EN
        input  r_avg,
`endif
        input  busy, r_valid, r_max, r_min, r_pp, r_idx, drop
    );

    modport slave (
        input  start, n_samp, s_valid, s_data, r_ready,
`ifdef GYR_RESP_CAPTURE_AVG_EN
        output r_avg,
`endif
        output busy, r_valid, r_max, r_min, r_pp, r_idx, drop
    );
endinterface

// File: rtl/gyr_resp_capture.sv
// Gyrator response capture: per sweep point, discards SETTLE samples, tracks
// signed max/min over n_samp samples and queues {max, min, pp, idx} in a 4-deep FIFO.
// Optional feature macro: GYR_RESP_CAPTURE_AVG_EN adds a per-point truncated average (r_avg).
module gyr_resp_capture #(
    parameter int DW     = 12,
    parameter int NW     = 8,
    parameter int SETTLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    gyr_resp_capture_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_ACQ, ST_PUSH} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam int         AW          = DW + NW;

    typedef struct packed {
        logic signed [DW-1:0] mx;
        logic signed [DW-1:0] mn;
        logic [DW:0]          pp;
        logic [NW-1:0]        idx;
`ifdef GYR_RESP_CAPTURE_AVG_EN
        logic signed [DW-1:0] avg;
`endif
    } entry_t;

    state_t               state_q, state_d;
    logic [NW-1:0]        nsamp_q, nsamp_d;
    logic [3:0]           settle_q, settle_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] min_q, min_d;
    logic [NW-1:0]        idx_q, idx_d;
    logic                 drop_q, drop_d;
    entry_t               mem_q [4];
    entry_t               mem_d [4];
    logic [1:0]           wr_q, wr_d;
    logic [1:0]           rd_q, rd_d;
    logic [2:0]           count_q, count_d;
`ifdef GYR_RESP_CAPTURE_AVG_EN
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] nsamp_ext;
`endif

    logic   push, pop, full, push_ok;
    entry_t entry;

    // FIFO handshake qualifiers; a pop in the PUSH cycle frees the slot being written
    always_comb begin
        push    = (state_q == ST_PUSH);
        pop     = (count_q != 3'd0) && bus.r_ready;
        full    = (count_q == 3'd4);
        push_ok = push && (!full || pop);
    end

    // Result word assembled from the running extremes
    always_comb begin
        entry     = '0;
        entry.mx  = max_q;
        entry.mn  = min_q;
        entry.pp  = {max_q[DW-1], max_q} - {min_q[DW-1], min_q};
        entry.idx = idx_q;
`ifdef GYR_RESP_CAPTURE_AVG_EN
        nsamp_ext = {{DW{1'b0}}, nsamp_q};
        entry.avg = DW'(acc_q / nsamp_ext);
`endif
    end

    // Capture FSM next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        nsamp_d  = nsamp_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        min_d    = min_q;
        idx_d    = idx_q;
        drop_d   = drop_q;
`ifdef GYR_RESP_CAPTURE_AVG_EN
        acc_d    = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    nsamp_d  = (bus.n_samp == '0) ? NW'(1) : bus.n_samp;
                    settle_d = '0;
                    cnt_d    = '0;
`ifdef GYR_RESP_CAPTURE_AVG_EN
                    acc_d    = '0;
`endif
                    state_d  = (SETTLE == 0) ? ST_ACQ : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.s_valid) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_ACQ;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
            end
            ST_ACQ: begin
                if (bus.s_valid) begin
                    if (cnt_q == '0) begin
                        max_d = bus.s_data;
                        min_d = bus.s_data;
                    end else begin
                        if (bus.s_data > max_q) max_d = bus.s_data;
                        if (bus.s_data < min_q) min_d = bus.s_data;
                    end
`ifdef GYR_RESP_CAPTURE_AVG_EN
                    acc_d = acc_q + AW'(bus.s_data);
`endif
                    cnt_d = cnt_q + NW'(1);
                    if (cnt_q + NW'(1) == nsamp_q) state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                state_d = ST_IDLE;
                idx_d   = idx_q + NW'(1);
                if (!push_ok) drop_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result FIFO pointer/occupancy and storage update
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wr_q] = entry;
            wr_d        = wr_q + 2'd1;
        end
        if (pop) rd_d = rd_q + 2'd1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State and storage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            nsamp_q  <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
            min_q    <= '0;
            idx_q    <= '0;
            drop_q   <= 1'b0;
            mem_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
`ifdef GYR_RESP_CAPTURE_AVG_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            nsamp_q  <= nsamp_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            min_q    <= min_d;
            idx_q    <= idx_d;
            drop_q   <= drop_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
`ifdef GYR_RESP_CAPTURE_AVG_EN
            acc_q    <= acc_d;
`endif
        end
    end

    // Outputs present the FIFO head; storage is cleared on reset so fields read 0
    always_comb begin
        bus.busy    = (state_q != ST_IDLE);
        bus.r_valid = (count_q != 3'd0);
        bus.r_max   = mem_q[rd_q].mx;
        bus.r_min   = mem_q[rd_q].mn;
        bus.r_pp    = mem_q[rd_q].pp;
        bus.r_idx   = mem_q[rd_q].idx;
        bus.drop    = drop_q;
`ifdef GYR_RESP_CAPTURE_AVG_EN
        bus.r_avg   = mem_q[rd_q].avg;
`endif
    end

endmodule

// File: tb/tb_gyr_resp_capture.sv
// Directed bench for gyr_resp_capture (default DW=12, NW=8, SETTLE=4).
// Average checks compile only with GYR_RESP_CAPTURE_AVG_EN defined.
module tb_gyr_resp_capture;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gyr_resp_capture_if #(.DW(12), .NW(8)) bus ();

    gyr_resp_capture #(.DW(12), .NW(8), .SETTLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start(input int n);
        bus.start  = 1'b1;
        bus.n_samp = 8'(n);
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic sample(input int v);
        bus.s_valid = 1'b1;
        bus.s_data  = 12'(v);
        tick();
        bus.s_valid = 1'b0;
    endtask

    // One-sample point: 4 settle samples, one ACQ sample, then the PUSH cycle
    task automatic capture1(input int v);
        do_start(1);
        repeat (4) sample(0);
        sample(v);
        tick();
    endtask

    task automatic pop_chk(input string tag, input int idx, input int mx);
        chk({tag, "_valid"}, bus.r_valid, 1);
        chk({tag, "_idx"}, bus.r_idx, idx);
        chk({tag, "_max"}, bus.r_max, mx);
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.n_samp  = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.r_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.r_valid, 0);
        chk("rst_max", bus.r_max, 0);
        chk("rst_min", bus.r_min, 0);
        chk("rst_pp", bus.r_pp, 0);
        chk("rst_idx", bus.r_idx, 0);
        chk("rst_drop", bus.drop, 0);

        // Basic point: settle 9,9,9,9 then 5,-7,12; a start during SETTLE is ignored
        do_start(3);
        chk("settle_busy", bus.busy, 1);
        sample(9);
        sample(9);
        bus.start  = 1'b1;
        bus.n_samp = 8'd1;
        tick();
        bus.start  = 1'b0;
        sample(9);
        sample(9);
        sample(5);
        sample(-7);
        chk("acq_novalid", bus.r_valid, 0);
        sample(12);
        chk("push_busy", bus.busy, 1);
        chk("push_novalid", bus.r_valid, 0);
        tick();
        chk("done_busy", bus.busy, 0);
        chk("b_min", bus.r_min, -7);
        chk("b_pp", bus.r_pp, 19);
        pop_chk("b", 0, 12);
        chk("b_empty", bus.r_valid, 0);

        // n_samp=0 treated as 1 with the most negative sample
        do_start(0);
        repeat (4) sample(0);
        sample(-2048);
        tick();
        chk("z_min", bus.r_min, -2048);
        chk("z_pp", bus.r_pp, 0);
        pop_chk("z", 1, -2048);

        // Full-scale peak-to-peak needs the extra pp bit
        do_start(2);
        repeat (4) sample(1);
        sample(2047);
        sample(-2048);
        tick();
        chk("fs_min", bus.r_min, -2048);
        chk("fs_pp", bus.r_pp, 4095);
        pop_chk("fs", 2, 2047);

        // Five captures with no reader: four kept, fifth dropped
        do_reset();
        for (int k = 0; k < 4; k++) capture1(10 + k);
        chk("ovf_nodrop", bus.drop, 0);
        chk("ovf_head_idx", bus.r_idx, 0);
        capture1(14);
        chk("ovf_drop", bus.drop, 1);
        chk("ovf_hold_max", bus.r_max, 10);
        for (int k = 0; k < 4; k++) pop_chk("ovf_drain", k, 10 + k);
        chk("ovf_empty", bus.r_valid, 0);
        chk("ovf_drop_sticky", bus.drop, 1);
        capture1(20);
        pop_chk("ovf_next", 5, 20);

        // Full FIFO with a pop in the PUSH cycle: result is stored
        do_reset();
        for (int k = 0; k < 4; k++) capture1(30 + k);
        do_start(1);
        repeat (4) sample(0);
        sample(34);
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        chk("sim_drop", bus.drop, 0);
        for (int k = 1; k < 5; k++) pop_chk("sim_drain", k, 30 + k);
        chk("sim_empty", bus.r_valid, 0);

        // Reset during ACQ after two samples abandons the point
        do_reset();
        do_start(5);
        repeat (4) sample(0);
        sample(1);
        sample(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_valid", bus.r_valid, 0);
        tick();
        chk("mid_valid2", bus.r_valid, 0);
        capture1(3);
        pop_chk("mid_next", 0, 3);

`ifdef GYR_RESP_CAPTURE_AVG_EN
        // Averages truncate toward zero
        do_start(3);
        repeat (4) sample(0);
        sample(3);
        sample(4);
        sample(-8);
        tick();
        chk("avg_a", bus.r_avg, 0);
        chk("avg_a_pp", bus.r_pp, 12);
        pop_chk("avg_a", 1, 4);
        do_start(2);
        repeat (4) sample(0);
        sample(7);
        sample(8);
        tick();
        chk("avg_b", bus.r_avg, 7);
        pop_chk("avg_b", 2, 8);
        do_start(2);
        repeat (4) sample(0);
        sample(-7);
        sample(-8);
        tick();
        chk("avg_c", bus.r_avg, -7);
        pop_chk("avg_c", 3, -7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
